dm_bytelane: RTL and testbench

DM_BYTELANE -- requirements
Module: dm_bytelane

---
 rtl/dm_bytelane.sv | 96 +++++++++
 tb/tb_dm_bytelane.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dm_bytelane.sv
// dm_bytelane: byte-lane data memory with fixed wait-state latency and alignment/range faults.
// Ports: clk, reset (sync, active-high); req/we/addr/wdata/size/sign_ext request an access;
// busy while not idle; ready pulses once on completion with rdata, exc and exc_code valid.
module dm_bytelane #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        exc,
  output logic [4:0]  exc_code
);
  localparam int          IW    = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        we_q, sext_q, fault;
  logic [1:0]  size_q, lane;
  logic [IW-1:0] idx;
  logic [31:0] wdata_q, off, cur, sh, ld, mask, merged;
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
  assign busy  = state != IDLE;
  assign off   = addr - BASE_ADDR;
  assign fault = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
                 addr < BASE_ADDR || off >= LIMIT;
  assign cur    = mem[idx];
  assign sh     = cur >> {lane, 3'b000};
  assign ld     = size_q == 2'b00 ? {{24{sext_q & sh[7]}}, sh[7:0]} :
                  size_q == 2'b01 ? {{16{sext_q & sh[15]}}, sh[15:0]} : cur;
  // half stores are aligned, so shifting data by the full lane offset lands on {addr[1],0}
  assign mask   = size_q == 2'b00 ? 32'h0000_00FF << {lane, 3'b000} :
                  size_q == 2'b01 ? 32'h0000_FFFF << {lane[1], 4'b0000} : 32'hFFFF_FFFF;
  assign merged = (cur & ~mask) | ((wdata_q << {lane, 3'b000}) & mask);
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      rdata    <= '0;
      exc      <= 1'b0;
      exc_code <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (req) begin
            we_q    <= we;
            wdata_q <= wdata;
            size_q  <= size;
            sext_q  <= sign_ext;
            lane    <= addr[1:0];
            idx     <= off[IW+1:2];
            if (fault) begin
              state    <= DONE;
              ready    <= 1'b1;
              rdata    <= '0;
              exc      <= 1'b1;
              exc_code <= we ? 5'd5 : 5'd4;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY);
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            state    <= DONE;
            ready    <= 1'b1;
            exc      <= 1'b0;
            exc_code <= '0;
            rdata    <= we_q ? 32'd0 : ld;
            if (we_q) mem[idx] <= merged;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: randomized and directed checks of three dm_bytelane builds against a byte-array model.
module tb_dm_bytelane;
  localparam int          LAT  [3] = '{1, 0, 4};
  localparam logic [31:0] BASE [3] = '{32'h0, 32'h100, 32'h0};
  localparam int          DEP  [3] = '{3072, 64, 3072};
  logic        clk = 0, reset = 1, req = 0, we = 0, sign_ext = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [1:0]  size = 0;
  logic [2:0]  busy, ready, exc;
  logic [31:0] rdata [3];
  logic [4:0]  exc_code [3];
  logic [7:0]  mm [3][12288];
  logic [31:0] last_rd [3];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  dm_bytelane #(.DEPTH_WORDS(3072), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size), .sign_ext(sign_ext),
    .busy(busy[0]), .ready(ready[0]), .rdata(rdata[0]), .exc(exc[0]), .exc_code(exc_code[0]));
  dm_bytelane #(.DEPTH_WORDS(64), .BASE_ADDR(32'h100), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size), .sign_ext(sign_ext),
    .busy(busy[1]), .ready(ready[1]), .rdata(rdata[1]), .exc(exc[1]), .exc_code(exc_code[1]));
  dm_bytelane #(.DEPTH_WORDS(3072), .BASE_ADDR(32'h0), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .size(size), .sign_ext(sign_ext),
    .busy(busy[2]), .ready(ready[2]), .rdata(rdata[2]), .exc(exc[2]), .exc_code(exc_code[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void m_clear();
    for (int k = 0; k < 3; k++) for (int i = 0; i < 12288; i++) mm[k][i] = 8'h00;
  endfunction
  function automatic bit m_fault(input int k, input logic [31:0] a, input logic [1:0] s);
    longint off = longint'(a) - longint'(BASE[k]);
    return s == 2'b11 || (a % (32'd1 << s)) != 0 || off < 0 || off >= 4 * DEP[k];
  endfunction
  function automatic logic [31:0] m_access(input int k, input bit w, input logic [31:0] a, input logic [31:0] wd,
                                           input logic [1:0] s, input bit sx);
    int off = int'(a - BASE[k]);
    int nb = 1 << s;
    logic [31:0] v = 0;
    for (int i = 0; i < nb; i++) begin
      if (w) mm[k][off + i] = 8'(wd >> (8 * i));
      else v |= 32'(mm[k][off + i]) << (8 * i);
    end
    if (!w && sx && nb < 4 && v[8 * nb - 1]) v |= 32'hFFFF_FFFF << (8 * nb);
    return w ? 32'd0 : v;
  endfunction
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s,
                      input bit sx, input int rst_at, input bit poke);
    int first [3], cnt [3], e;
    logic [31:0] g_rd [3];
    logic g_exc [3];
    logic [4:0] g_code [3];
    for (int k = 0; k < 3; k++) begin first[k] = -1; cnt[k] = 0; end
    @(negedge clk);
    we = w; addr = a; wdata = wd; size = s; sign_ext = sx; req = 1;
    @(negedge clk);
    req = 0;
    for (e = 0; e < 40; e++) begin
      if (e > 0) @(negedge clk);
      for (int k = 0; k < 3; k++) if (ready[k]) begin
        cnt[k]++;
        if (first[k] < 0) first[k] = e;
        g_rd[k] = rdata[k]; g_exc[k] = exc[k]; g_code[k] = exc_code[k];
      end
      reset = rst_at >= 0 && e == rst_at - 1;
      if (poke && e == 1) begin req = 1; we = 1; addr = a ^ 32'h40; wdata = ~wd; size = 2'b10; end
      if (poke && e == 2) req = 0;
      if (e >= 1 && busy == 3'b000 && (rst_at < 0 || e >= rst_at)) break;
    end
    chk("idle_bound", 32'(e >= 40), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bit f = m_fault(k, a, s);
      int ee = f ? 0 : LAT[k] + 1;
      bit exp_rdy = rst_at < 0 || ee < rst_at;
      chk($sformatf("rdy_cnt%0d", k), 32'(cnt[k]), 32'(exp_rdy));
      if (exp_rdy) begin
        logic [31:0] exp_rd = f ? 32'd0 : m_access(k, w, a, wd, s, sx);
        chk($sformatf("rdy_lat%0d", k), 32'(first[k]), 32'(ee));
        chk($sformatf("rdata%0d a=%h s=%0d", k, a, s), g_rd[k], exp_rd);
        chk($sformatf("exc%0d", k), 32'(g_exc[k]), 32'(f));
        chk($sformatf("code%0d", k), 32'(g_code[k]), f ? (w ? 32'd5 : 32'd4) : 32'd0);
        last_rd[k] = g_rd[k];
      end
    end
    if (rst_at >= 0) m_clear();
  endtask
  task automatic hold_test();
    int t [3][4], n [3], e;
    for (int k = 0; k < 3; k++) n[k] = 0;
    @(negedge clk);
    we = 0; addr = 32'h104; size = 2'b10; sign_ext = 0; req = 1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (ready[k] && n[k] < 4) begin t[k][n[k]] = c; n[k]++; end
    end
    req = 0;
    for (e = 0; e < 20 && busy != 3'b000; e++) @(negedge clk);
    chk("hold_idle_bound", 32'(e >= 20), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_n%0d", k), 32'(n[k] >= 3), 32'd1);
      if (n[k] >= 3) begin
        chk($sformatf("hold_first%0d", k), 32'(t[k][0]), 32'(LAT[k] + 1));
        chk($sformatf("hold_gap%0d", k), 32'(t[k][1] - t[k][0]), 32'(LAT[k] + 3));
        chk($sformatf("hold_gap%0d", k), 32'(t[k][2] - t[k][1]), 32'(LAT[k] + 3));
      end
    end
  endtask
  initial begin
    m_clear();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst_ready%0d", k), 32'(ready[k]), 32'd0);
      chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
      chk($sformatf("rst_exc%0d", k), 32'(exc[k]), 32'd0);
      chk($sformatf("rst_code%0d", k), 32'(exc_code[k]), 32'd0);
    end
    reset = 0;
    xact(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, -1, 0);
    xact(0, 32'h10, 32'h0, 2'b10, 0, -1, 0);
    chk("d_word", last_rd[0], 32'hDEADBEEF);
    xact(1, 32'h12, 32'h7F, 2'b00, 0, -1, 0);
    xact(0, 32'h13, 32'h0, 2'b00, 1, -1, 0);
    chk("d_byte_sx", last_rd[0], 32'hFFFFFFDE);
    xact(0, 32'h12, 32'h0, 2'b01, 0, -1, 0);
    chk("d_half_zx", last_rd[0], 32'h0000DE7F);
    xact(0, 32'h10, 32'h0, 2'b10, 1, -1, 0);
    chk("d_word2", last_rd[0], 32'hDE7FBEEF);
    xact(0, 32'h11, 32'h0, 2'b10, 0, -1, 0);
    xact(1, 32'h13, 32'h5555, 2'b01, 0, -1, 0);
    xact(0, 32'h10, 32'h0, 2'b10, 0, -1, 0);
    chk("d_unchanged", last_rd[0], 32'hDE7FBEEF);
    xact(1, 32'd12288, 32'h1, 2'b10, 0, -1, 0);
    xact(1, 32'h0FC, 32'h1, 2'b10, 0, -1, 0);
    xact(1, 32'h200, 32'h1, 2'b10, 0, -1, 0);
    xact(1, 32'h140, 32'hA5A51234, 2'b10, 0, -1, 1);
    xact(0, 32'h100, 32'h0, 2'b10, 0, -1, 0);
    xact(0, 32'h140, 32'h0, 2'b10, 0, -1, 0);
    hold_test();
    xact(1, 32'h20, 32'h12345678, 2'b10, 0, 2, 0);
    xact(0, 32'h20, 32'h0, 2'b10, 0, -1, 0);
    chk("d_reset_abort", last_rd[2], 32'h0);
    xact(0, 32'h10, 32'h0, 2'b10, 0, -1, 0);
    chk("d_reset_clear", last_rd[0], 32'h0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 32'h3010)) : 32'($urandom_range(32'hF0, 32'h210));
      logic [1:0] s = $urandom_range(0, 9) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 3) != 0 ? a & ~((32'd1 << s) - 32'd1) : a;
      xact(1'($urandom), a, $urandom, s, 1'($urandom), -1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
